// File: rtl/pa_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pa_pipe_pkg
//  Purpose  : Shared definitions for the PA-RISC decode/writeback tag logic.
//             Holds the default register address width, the hard-wired zero
//             register number and the destination-select encodings used by
//             the decoder to steer the target-register multiplexer.
//  Revision : 1.0 - initial release
// ============================================================================
package pa_pipe_pkg;

    // General register file addressing
    localparam int       PA_AW = 5;
    localparam logic [4:0] GR0 = 5'd0;

    // Destination select encodings presented on the sel input of
    // dest_reg_tag_pipe. NONE is out of range for a 3-candidate mux and
    // therefore resolves to register 0, meaning no tracked write.
    typedef enum logic [1:0] {
        DEST_SEL_RT_A = 2'd0,
        DEST_SEL_RT_B = 2'd1,
        DEST_SEL_LINK = 2'd2,
        DEST_SEL_NONE = 2'd3
    } dest_sel_e;

endpackage : pa_pipe_pkg
`default_nettype wire

// File: rtl/mux_n_to_1.sv
`default_nettype none
// ============================================================================
//  Module   : mux_n_to_1
//  Purpose  : Combinational N:1 multiplexer of W-bit words. Any select value
//             of N or above drives an all-zero output, so an out-of-range
//             select can never produce X or alias another input.
//  Ports    : i_sel  [SELW-1:0]  word select
//             i_data [N*W-1:0]   input words, word i at [i*W +: W]
//             o_data [W-1:0]     selected word (0 when i_sel >= N)
//  Revision : 1.0 - initial release
// ============================================================================
module mux_n_to_1 #(
    parameter int W    = 5,
    parameter int N    = 3,
    parameter int SELW = $clog2(N + 1)
) (
    input  logic [SELW-1:0] i_sel,
    input  logic [N*W-1:0]  i_data,
    output logic [W-1:0]    o_data
);

    always_comb begin
        o_data = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(i_sel) == i) begin
                o_data = i_data[i*W +: W];
            end
        end
    end

endmodule : mux_n_to_1
`default_nettype wire

// File: rtl/dest_reg_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : dest_reg_tag_pipe
//  Purpose  : Destination-register selector and in-flight tag pipeline.
//             Selects the target register of the decoding instruction from
//             NSRC candidates, carries the tag through DEPTH stages
//             (EX..WB) with stall bubbles and partial flush, and reports the
//             youngest stage holding each source operand for forwarding.
//  Ports    : clk, rst_n             clock, async active-low reset
//             sel [SELW-1:0]         destination select (>= NSRC -> 0)
//             src_addr [NSRC*AW-1:0] candidate addresses
//             wr_en_in, stall, flush decode-stage controls
//             rs1, rs2 [AW-1:0]      source operands of decoding instr
//             sel_addr [AW-1:0]      combinational selected address
//             tag_q [DEPTH*AW-1:0]   per-stage tags
//             vld_q [DEPTH-1:0]      per-stage valids
//             fwd1, fwd2 [FW-1:0]    youngest matching stage + 1, 0 = none
//             wb_addr, wb_en         writeback stage tag / valid
//  Revision : 1.0 - initial release
// ============================================================================
module dest_reg_tag_pipe
    import pa_pipe_pkg::*;
#(
    parameter  int AW          = PA_AW,
    parameter  int NSRC        = 3,
    parameter  int DEPTH       = 3,
    parameter  int FLUSH_DEPTH = 1,
    localparam int SELW        = $clog2(NSRC + 1),
    localparam int FW          = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SELW-1:0]      sel,
    input  logic [NSRC*AW-1:0]   src_addr,
    input  logic                 wr_en_in,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [AW-1:0]        rs1,
    input  logic [AW-1:0]        rs2,
    output logic [AW-1:0]        sel_addr,
    output logic [DEPTH*AW-1:0]  tag_q,
    output logic [DEPTH-1:0]     vld_q,
    output logic [FW-1:0]        fwd1,
    output logic [FW-1:0]        fwd2,
    output logic [AW-1:0]        wb_addr,
    output logic                 wb_en
);

    logic [AW-1:0]    w_sel_addr;
    logic             w_entry_vld;
    logic [AW-1:0]    w_entry_tag;
    logic [AW-1:0]    r_tag [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] w_hit1;
    logic [DEPTH-1:0] w_hit2;

    // ------------------------------------------------------------------
    // Destination select
    // ------------------------------------------------------------------
    mux_n_to_1 #(
        .W    (AW),
        .N    (NSRC),
        .SELW (SELW)
    ) u_dest_mux (
        .i_sel  (sel),
        .i_data (src_addr),
        .o_data (w_sel_addr)
    );

    assign sel_addr = w_sel_addr;

    // Writes to r0 are architecturally dropped, so they never occupy a
    // tracked slot. The tag is zeroed for bubbles so idle stages read 0.
    assign w_entry_vld = wr_en_in & ~stall & ~flush & (w_sel_addr != '0);
    assign w_entry_tag = w_entry_vld ? w_sel_addr : '0;

    // ------------------------------------------------------------------
    // Tag pipeline: always advances. Flush clears the stages that would
    // receive the squashed younger instructions (1..FLUSH_DEPTH-1); stage 0
    // already takes a bubble through w_entry_vld.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_vld[0] <= w_entry_vld;
            r_tag[0] <= w_entry_tag;
            for (int s = 1; s < DEPTH; s++) begin
                if (flush && (s < FLUSH_DEPTH)) begin
                    r_vld[s] <= 1'b0;
                    r_tag[s] <= '0;
                end else begin
                    r_vld[s] <= r_vld[s-1];
                    r_tag[s] <= r_tag[s-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-stage outputs and operand match vectors
    // ------------------------------------------------------------------
    generate
        for (genvar s = 0; s < DEPTH; s++) begin : g_stage
            assign tag_q[s*AW +: AW] = r_tag[s];
            assign w_hit1[s]         = r_vld[s] && (r_tag[s] == rs1);
            assign w_hit2[s]         = r_vld[s] && (r_tag[s] == rs2);
        end
    endgenerate

    assign vld_q   = r_vld;
    assign wb_addr = r_tag[DEPTH-1];
    assign wb_en   = r_vld[DEPTH-1];

    // Priority encode: scan oldest to youngest so the youngest hit is the
    // last assignment and wins. r0 operands never forward.
    always_comb begin
        fwd1 = '0;
        fwd2 = '0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            if (w_hit1[s] && (rs1 != '0)) begin
                fwd1 = FW'(s + 1);
            end
            if (w_hit2[s] && (rs2 != '0)) begin
                fwd2 = FW'(s + 1);
            end
        end
    end

endmodule : dest_reg_tag_pipe
`default_nettype wire

// File: tb/tb_dest_reg_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dest_reg_tag_pipe
//  Purpose  : Self-checking bench for dest_reg_tag_pipe. Two instances share
//             the stimulus: inst A uses default parameters, inst B uses
//             FLUSH_DEPTH=2. Directed sequences plus a randomized phase
//             checked against an in-flight-list reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dest_reg_tag_pipe;

    logic        clk;
    logic        rst_n;
    logic [1:0]  sel;
    logic [14:0] src_addr;
    logic        wr_en_in;
    logic        stall;
    logic        flush;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    logic [4:0]  sel_addr_a, wb_addr_a, sel_addr_b, wb_addr_b;
    logic [14:0] tag_q_a, tag_q_b;
    logic [2:0]  vld_q_a, vld_q_b;
    logic [1:0]  fwd1_a, fwd2_a, fwd1_b, fwd2_b;
    logic        wb_en_a, wb_en_b;

    int checks   = 0;
    int failures = 0;

    dest_reg_tag_pipe u_dut_a (
        .clk(clk), .rst_n(rst_n), .sel(sel), .src_addr(src_addr),
        .wr_en_in(wr_en_in), .stall(stall), .flush(flush), .rs1(rs1), .rs2(rs2),
        .sel_addr(sel_addr_a), .tag_q(tag_q_a), .vld_q(vld_q_a),
        .fwd1(fwd1_a), .fwd2(fwd2_a), .wb_addr(wb_addr_a), .wb_en(wb_en_a)
    );

    dest_reg_tag_pipe #(.FLUSH_DEPTH(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .sel(sel), .src_addr(src_addr),
        .wr_en_in(wr_en_in), .stall(stall), .flush(flush), .rs1(rs1), .rs2(rs2),
        .sel_addr(sel_addr_b), .tag_q(tag_q_b), .vld_q(vld_q_b),
        .fwd1(fwd1_b), .fwd2(fwd2_b), .wb_addr(wb_addr_b), .wb_en(wb_en_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Reference model: list of in-flight writes, each with its stage age.
    // ------------------------------------------------------------------
    typedef struct {
        logic [4:0] tag;
        int         age;
        int         inst;
    } inflight_t;

    inflight_t q[$];

    function automatic logic [4:0] ref_sel(input logic [1:0] s, input logic [14:0] src);
        if (s < 2'd3) return src[s*5 +: 5];
        return 5'd0;
    endfunction

    function automatic int fdepth(input int inst);
        return (inst == 0) ? 1 : 2;
    endfunction

    task automatic model_edge();
        inflight_t  nq[$];
        inflight_t  e;
        logic [4:0] sa;
        logic       ev;
        if (!rst_n) begin
            q.delete();
            return;
        end
        sa = ref_sel(sel, src_addr);
        ev = wr_en_in && !stall && !flush && (sa != 5'd0);
        foreach (q[i]) begin
            e = q[i];
            // entries younger than the flush reach are squashed
            if (flush && (e.age < fdepth(e.inst) - 1)) continue;
            e.age = e.age + 1;
            if (e.age < 3) nq.push_back(e);
        end
        if (ev) begin
            for (int k = 0; k < 2; k++) nq.push_back('{sa, 0, k});
        end
        q = nq;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [2:0]  ev;
        logic [14:0] et;
        int          f1, f2;
        for (int k = 0; k < 2; k++) begin
            ev = '0; et = '0; f1 = 0; f2 = 0;
            foreach (q[i]) begin
                if (q[i].inst == k) begin
                    ev[q[i].age]          = 1'b1;
                    et[q[i].age*5 +: 5]   = q[i].tag;
                    if (rs1 != 0 && q[i].tag == rs1 && (f1 == 0 || q[i].age + 1 < f1)) f1 = q[i].age + 1;
                    if (rs2 != 0 && q[i].tag == rs2 && (f2 == 0 || q[i].age + 1 < f2)) f2 = q[i].age + 1;
                end
            end
            chk($sformatf("rnd_sel_addr%0d", k), 32'(k == 0 ? sel_addr_a : sel_addr_b), 32'(ref_sel(sel, src_addr)));
            chk($sformatf("rnd_vld%0d", k),      32'(k == 0 ? vld_q_a : vld_q_b), 32'(ev));
            chk($sformatf("rnd_tag%0d", k),      32'(k == 0 ? tag_q_a : tag_q_b), 32'(et));
            chk($sformatf("rnd_fwd1_%0d", k),    32'(k == 0 ? fwd1_a : fwd1_b), 32'(f1));
            chk($sformatf("rnd_fwd2_%0d", k),    32'(k == 0 ? fwd2_a : fwd2_b), 32'(f2));
            chk($sformatf("rnd_wb_en%0d", k),    32'(k == 0 ? wb_en_a : wb_en_b), 32'(ev[2]));
            chk($sformatf("rnd_wb_addr%0d", k),  32'(k == 0 ? wb_addr_a : wb_addr_b), 32'(et[14:10]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr_en_in = 1'b0; stall = 1'b0; flush = 1'b0;
        sel = 2'd3; rs1 = 5'd0; rs2 = 5'd0;
    endtask

    // Combinational select vectors
    typedef struct {
        logic [1:0]  sel;
        logic [14:0] src;
        logic [4:0]  exp;
    } mux_vec_t;

    mux_vec_t vecs[6];

    initial begin
        vecs[0] = '{2'd0, {5'd31, 5'd9, 5'd4}, 5'd4};
        vecs[1] = '{2'd1, {5'd31, 5'd9, 5'd4}, 5'd9};
        vecs[2] = '{2'd2, {5'd31, 5'd9, 5'd4}, 5'd31};
        vecs[3] = '{2'd3, {5'd31, 5'd9, 5'd4}, 5'd0};
        vecs[4] = '{2'd0, {5'd1,  5'd2, 5'd0}, 5'd0};
        vecs[5] = '{2'd2, {5'd17, 5'd3, 5'd8}, 5'd17};

        rst_n = 1'b0;
        src_addr = '0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        chk("rst_vld_a", 32'(vld_q_a), 0);
        chk("rst_tag_a", 32'(tag_q_a), 0);
        chk("rst_wb_en_a", 32'(wb_en_a), 0);
        chk("rst_fwd1_a", 32'(fwd1_a), 0);
        chk("rst_vld_b", 32'(vld_q_b), 0);
        rst_n = 1'b1;
        cycle();

        // Table-driven select vectors (write enable low: no state change)
        foreach (vecs[i]) begin
            sel = vecs[i].sel;
            src_addr = vecs[i].src;
            #1;
            chk($sformatf("mux_vec%0d_a", i), 32'(sel_addr_a), 32'(vecs[i].exp));
            chk($sformatf("mux_vec%0d_b", i), 32'(sel_addr_b), 32'(vecs[i].exp));
        end
        idle_inputs();
        cycle();

        // T2: select and latency
        src_addr = {5'd31, 5'd9, 5'd4}; sel = 2'd1; wr_en_in = 1'b1;
        #1 chk("t2_sel_addr", 32'(sel_addr_a), 9);
        cycle(); idle_inputs();
        chk("t2_e1_vld", 32'(vld_q_a), 3'b001);
        chk("t2_e1_tag0", 32'(tag_q_a[4:0]), 9);
        chk("t2_e1_wb_en", 32'(wb_en_a), 0);
        cycle();
        chk("t2_e2_vld", 32'(vld_q_a), 3'b010);
        chk("t2_e2_wb_en", 32'(wb_en_a), 0);
        cycle();
        chk("t2_e3_wb_en", 32'(wb_en_a), 1);
        chk("t2_e3_wb_addr", 32'(wb_addr_a), 9);
        cycle();
        chk("t2_e4_wb_en", 32'(wb_en_a), 0);
        chk("t2_e4_vld", 32'(vld_q_a), 0);

        // T3: select NONE and r0
        sel = 2'd3; wr_en_in = 1'b1; rs1 = 5'd0;
        #1 chk("t3_none_sel_addr", 32'(sel_addr_a), 0);
        cycle();
        chk("t3_none_vld", 32'(vld_q_a), 0);
        chk("t3_fwd1_r0", 32'(fwd1_a), 0);
        src_addr = {5'd31, 5'd9, 5'd0}; sel = 2'd0;
        #1 chk("t3_r0_sel_addr", 32'(sel_addr_a), 0);
        cycle(); idle_inputs();
        chk("t3_r0_vld", 32'(vld_q_a), 0);

        // T4: stall bubble
        src_addr = {5'd6, 5'd5, 5'd4};
        wr_en_in = 1'b1; sel = 2'd0; stall = 1'b0; cycle();
        sel = 2'd1; stall = 1'b1; cycle();
        sel = 2'd1; stall = 1'b0; cycle();
        chk("t4_e3_vld", 32'(vld_q_a), 3'b101);
        chk("t4_e3_wb", 32'({wb_en_a, wb_addr_a}), {1'b1, 5'd4});
        sel = 2'd2; cycle(); idle_inputs();
        chk("t4_e4_vld", 32'(vld_q_a), 3'b011);
        chk("t4_e4_tags", 32'(tag_q_a[9:0]), {5'd5, 5'd6});
        chk("t4_bubble_wb_en", 32'(wb_en_a), 0);
        cycle();
        chk("t4_e5_wb", 32'({wb_en_a, wb_addr_a}), {1'b1, 5'd5});
        cycle();
        chk("t4_e6_wb", 32'({wb_en_a, wb_addr_a}), {1'b1, 5'd6});
        cycle();
        chk("t4_e7_wb_en", 32'(wb_en_a), 0);

        // T5: flush, depth 1 (A) vs depth 2 (B)
        src_addr = {5'd9, 5'd8, 5'd7};
        wr_en_in = 1'b1; sel = 2'd0; cycle();
        sel = 2'd1; cycle();
        sel = 2'd2; flush = 1'b1; cycle(); idle_inputs();
        chk("t5_b_vld", 32'(vld_q_b), 3'b100);
        chk("t5_b_wb", 32'({wb_en_b, wb_addr_b}), {1'b1, 5'd7});
        chk("t5_a_vld", 32'(vld_q_a), 3'b110);
        cycle();
        chk("t5_b_squashed", 32'({wb_en_b, vld_q_b}), 0);
        chk("t5_a_wb8", 32'({wb_en_a, wb_addr_a}), {1'b1, 5'd8});
        cycle();
        chk("t5_a_drained", 32'(wb_en_a), 0);

        // T6: forwarding priority
        src_addr = {5'd3, 5'd0, 5'd12};
        wr_en_in = 1'b1; sel = 2'd0; cycle();
        sel = 2'd2; cycle();
        sel = 2'd0; cycle(); idle_inputs();
        rs1 = 5'd12; rs2 = 5'd12;
        #1;
        chk("t6_fwd1_s0", 32'(fwd1_a), 1);
        chk("t6_fwd2_s0", 32'(fwd2_a), 1);
        cycle();
        chk("t6_fwd1_s1", 32'(fwd1_a), 2);
        cycle();
        chk("t6_fwd1_s2", 32'(fwd1_a), 3);
        chk("t6_fwd2_s2", 32'(fwd2_a), 3);
        cycle();
        chk("t6_fwd1_none", 32'(fwd1_a), 0);

        // T1: asynchronous reset mid-stream
        src_addr = {5'd11, 5'd10, 5'd1};
        wr_en_in = 1'b1; sel = 2'd0; cycle();
        sel = 2'd1; cycle();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_vld_a", 32'(vld_q_a), 0);
        chk("t1_tag_a", 32'(tag_q_a), 0);
        chk("t1_wb_en_a", 32'(wb_en_a), 0);
        chk("t1_vld_b", 32'(vld_q_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        idle_inputs();

        // Randomized phase against the reference model
        for (int n = 0; n < 400; n++) begin
            sel      = 2'($urandom_range(0, 3));
            src_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wr_en_in = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 6) == 0);
            rs1      = 5'($urandom_range(0, 7));
            rs2      = 5'($urandom_range(0, 7));
            #1;
            check_model();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dest_reg_tag_pipe
`default_nettype wire
